// File: rtl/edge_event_bank.sv
// Multi-channel edge-event detector: per-channel synchroniser, shared-threshold
// debounce, mode-selected edge pulses, W1C sticky status and a masked interrupt.
module edge_event_bank #(
   parameter int NUM_CH      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [NUM_CH-1:0]     data_in,
   input  logic [2*NUM_CH-1:0]   mode,
   input  logic [DEB_WIDTH-1:0]  deb_cycles,
   input  logic [NUM_CH-1:0]     clr,
   input  logic [NUM_CH-1:0]     irq_mask,
   output logic [NUM_CH-1:0]     level,
   output logic [NUM_CH-1:0]     edge_pulse,
   output logic [NUM_CH-1:0]     status,
   output logic                  irq
);

   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
   logic [NUM_CH-1:0][DEB_WIDTH-1:0]   cnt_q, cnt_d;
   logic [NUM_CH-1:0]                  level_q, level_d;
   logic [NUM_CH-1:0]                  pulse_q, pulse_d;
   logic [NUM_CH-1:0]                  status_q, status_d;
   logic [NUM_CH-1:0]                  s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = data_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // The >= compare lets a lowered threshold fire immediately instead of
   // letting the counter run past D and wrap.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      pulse_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ena) begin
            if (s[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] >= deb_cycles) begin
               level_d[i] = s[i];
               cnt_d[i]   = '0;
               pulse_d[i] = s[i] ? mode[2*i] : mode[2*i+1];
            end else begin
               cnt_d[i] = cnt_q[i] + DEB_WIDTH'(1);
            end
         end
      end
      status_d = (status_q & ~clr) | pulse_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         level_q  <= '0;
         pulse_q  <= '0;
         status_q <= '0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         pulse_q  <= pulse_d;
         status_q <= status_d;
      end
   end

   assign level      = level_q;
   assign edge_pulse = pulse_q;
   assign status     = status_q;
   assign irq        = |(status_q & irq_mask);

endmodule

// File: tb/tb_edge_event_bank.sv
// Directed bench for edge_event_bank with default parameters (8 ch, 2 sync, 4-bit D).
module tb_edge_event_bank;

   logic        clk = 1'b0;
   logic        rst, ena;
   logic [7:0]  data_in, clr, irq_mask;
   logic [15:0] mode;
   logic [3:0]  deb_cycles;
   logic [7:0]  level, edge_pulse, status;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_level;
      logic [7:0] exp_pulse;
      logic [7:0] exp_status;
   } vec_t;

   vec_t tbl [14];

   edge_event_bank dut (
      .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .mode(mode),
      .deb_cycles(deb_cycles), .clr(clr), .irq_mask(irq_mask),
      .level(level), .edge_pulse(edge_pulse), .status(status), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; data_in = '0; ena = 1'b1; clr = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ena = 1'b1; data_in = '0; clr = '0; irq_mask = '0;
      mode = '0; deb_cycles = '0;

      // Reset values: inputs held high through reset, event 6th edge after release
      mode = 16'hFFFF; deb_cycles = 4'd3; irq_mask = 8'hFF;
      #1;
      rst = 1'b1; data_in = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("rst_level",  level,      0);
         chk("rst_pulse",  edge_pulse, 0);
         chk("rst_status", status,     0);
         chk("rst_irq",    irq,        0);
      end
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("rel_level",  level,      (k >= 6) ? 8'hFF : 8'h00);
         chk("rel_pulse",  edge_pulse, (k == 6) ? 8'hFF : 8'h00);
         chk("rel_status", status,     (k >= 6) ? 8'hFF : 8'h00);
         chk("rel_irq",    irq,        (k >= 6) ? 1 : 0);
      end

      // Mode coverage, D=0: ch0 off, ch1 rise, ch2 fall, ch3 both
      do_reset();
      mode = 16'h00E4; deb_cycles = 4'd0; irq_mask = 8'h00;
      tbl = '{
         '{8'h0F, 8'h00, 8'h00, 8'h00},
         '{8'h0F, 8'h00, 8'h00, 8'h00},
         '{8'h0F, 8'h0F, 8'h0A, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h0F, 8'h0F, 8'h00, 8'h0A},
         '{8'h00, 8'h0F, 8'h00, 8'h0A},
         '{8'h00, 8'h0F, 8'h00, 8'h0A},
         '{8'h00, 8'h00, 8'h0C, 8'h0E},
         '{8'h00, 8'h00, 8'h00, 8'h0E}
      };
      for (int i = 0; i < 14; i++) begin
         data_in = tbl[i].din;
         step();
         chk("mode_level",  level,      tbl[i].exp_level);
         chk("mode_pulse",  edge_pulse, tbl[i].exp_pulse);
         chk("mode_status", status,     tbl[i].exp_status);
         chk("mode_irq",    irq,        0);
      end

      // Status / clr / irq on ch2 (mask 04) and masked ch5
      do_reset();
      mode = 16'h0C30; deb_cycles = 4'd0; irq_mask = 8'h04;
      data_in = 8'h04;
      step(); step(); step();
      chk("st_set_pulse",  edge_pulse, 8'h04);
      chk("st_set_status", status,     8'h04);
      chk("st_set_irq",    irq,        1);
      clr = 8'h04;
      step();
      clr = 8'h00;
      chk("st_clr_status", status, 8'h00);
      chk("st_clr_irq",    irq,    0);
      data_in = 8'h00;
      step(); step(); step();
      chk("st_fall_status", status, 8'h04);
      data_in = 8'h04;
      step(); step();
      clr = 8'h04;
      step();
      chk("st_win_pulse",  edge_pulse, 8'h04);
      chk("st_win_status", status,     8'h04);
      clr = 8'h00;
      step();
      chk("st_win_hold", status, 8'h04);
      chk("st_win_irq",  irq,    1);
      clr = 8'h04;
      step();
      clr = 8'h00;
      chk("st_clr2_irq", irq, 0);
      data_in = 8'h24;
      step(); step(); step();
      chk("st_mask_pulse",  edge_pulse, 8'h20);
      chk("st_mask_status", status,     8'h20);
      chk("st_mask_irq",    irq,        0);

      // ena as 1-in-4 tick, D=2: enabled edges 4, 8, 12 -> event at 12; clr at 14 with ena=0
      do_reset();
      mode = 16'h0001; deb_cycles = 4'd2; irq_mask = 8'h01;
      for (int c = 0; c < 20; c++) begin
         ena     = (c % 4 == 0);
         data_in = 8'h01;
         clr     = (c == 14) ? 8'h01 : 8'h00;
         step();
         chk("ena_pulse",  edge_pulse, (c == 12) ? 8'h01 : 8'h00);
         chk("ena_level",  level,      (c >= 12) ? 8'h01 : 8'h00);
         chk("ena_status", status,     (c == 12 || c == 13) ? 8'h01 : 8'h00);
      end
      ena = 1'b1; clr = 8'h00;

      // Glitch rejection, D=3: 3-cycle pulse rejected, 4-cycle pulse accepted
      do_reset();
      mode = 16'h0001; deb_cycles = 4'd3; irq_mask = 8'h00;
      for (int c = 0; c < 25; c++) begin
         data_in = (c < 3 || (c >= 10 && c < 14)) ? 8'h01 : 8'h00;
         step();
         chk("gl_pulse", edge_pulse, (c == 15) ? 8'h01 : 8'h00);
         chk("gl_level", level,      (c >= 15 && c <= 18) ? 8'h01 : 8'h00);
      end

      // Runtime D change: D=7, cnt reaches 5 after edge 6, D=2 written before edge 7
      do_reset();
      mode = 16'h0003; deb_cycles = 4'd7; irq_mask = 8'h00;
      for (int c = 0; c < 17; c++) begin
         data_in = (c < 9) ? 8'h01 : 8'h00;
         if (c == 7) deb_cycles = 4'd2;
         step();
         chk("dchg_pulse", edge_pulse, (c == 7 || c == 13) ? 8'h01 : 8'h00);
         chk("dchg_level", level,      (c >= 7 && c < 13) ? 8'h01 : 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
